simd_addsub_pipe: RTL and testbench



---
 rtl/simd_pkg.sv | 46 ++++
 rtl/simd_nibble_add.sv | 14 +
 rtl/simd_addsub_pipe.sv | 133 +++++++++++++
 tb/tb_simd_addsub_pipe.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared constants and lane-geometry helpers for the SIMD add/subtract unit.
package simd_pkg;

   localparam int NIB_W   = 4;
   localparam int MAX_NIB = 16;

   localparam logic [1:0] MODE_4B  = 2'b00;
   localparam logic [1:0] MODE_8B  = 2'b01;
   localparam logic [1:0] MODE_16B = 2'b10;
   localparam logic [1:0] MODE_32B = 2'b11;

   // Lane size in nibbles; a mode wider than the datapath collapses to one full-width lane.
   function automatic int lane_nibbles(input logic [1:0] bitnum, input int nib);
      int l;
      case (bitnum)
         MODE_4B:  l = 1;
         MODE_8B:  l = 2;
         MODE_16B: l = 4;
         MODE_32B: l = 8;
         default:  l = 1;
      endcase
      if (l > nib) l = nib;
      return l;
   endfunction

   function automatic logic [MAX_NIB-1:0] lane_start_mask(input logic [1:0] bitnum, input int nib);
      logic [MAX_NIB-1:0] m;
      int                 l;
      l = lane_nibbles(bitnum, nib);
      m = '0;
      for (int i = 0; i < MAX_NIB; i++)
         m[i] = (i < nib) && ((i & (l - 1)) == 0);
      return m;
   endfunction

   function automatic logic [MAX_NIB-1:0] lane_top_mask(input logic [1:0] bitnum, input int nib);
      logic [MAX_NIB-1:0] m;
      int                 l;
      l = lane_nibbles(bitnum, nib);
      m = '0;
      for (int i = 0; i < MAX_NIB; i++)
         m[i] = (i < nib) && ((i & (l - 1)) == (l - 1));
      return m;
   endfunction

endpackage

// File: rtl/simd_nibble_add.sv
// 4-bit adder slice with carry-in; one per nibble of the carry-resolve stage.
module simd_nibble_add
   import simd_pkg::*;
(
   input  logic [NIB_W-1:0] a,
   input  logic [NIB_W-1:0] b,
   input  logic             cin,
   output logic [NIB_W-1:0] s,
   output logic             cout
);

   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};

endmodule

// File: rtl/simd_addsub_pipe.sv
// Two-stage SIMD add/subtract with per-transaction lane width and valid/ready flow control.
// Optional per-lane unsigned saturation is built only when SIMD_SAT_EN is defined.
module simd_addsub_pipe
   import simd_pkg::*;
#(
   parameter int NIB = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NIB_W*NIB-1:0] dataA,
   input  logic [NIB_W*NIB-1:0] dataB,
   input  logic [1:0]           bitnum,
   input  logic                 op_sub,
   input  logic                 sat,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NIB_W*NIB-1:0] sum,
   output logic [NIB-1:0]       carry
);

   localparam int W = NIB_W * NIB;

   // ---------------- S1: operand inversion, nibble partial sums, lane masks
   logic                     s1_valid, s1_sub, s1_adv;
   logic [NIB-1:0]           s1_start, s1_top;
   logic [NIB-1:0][NIB_W:0]  s1_p, p_next;
   logic [W-1:0]             b_eff;
   logic [MAX_NIB-1:0]       start_full, top_full;

   assign start_full = lane_start_mask(bitnum, NIB);
   assign top_full   = lane_top_mask(bitnum, NIB);
   assign b_eff      = op_sub ? ~dataB : dataB;

   if (NIB < MAX_NIB) begin : g_mask_hi
      logic unused_mask_hi;
      assign unused_mask_hi = ^{start_full[MAX_NIB-1:NIB], top_full[MAX_NIB-1:NIB]};
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      p_next = '0;
      for (int i = 0; i < NIB; i++)
         p_next[i] = {1'b0, dataA[NIB_W*i +: NIB_W]} + {1'b0, b_eff[NIB_W*i +: NIB_W]};
   end

   assign s1_adv   = !out_valid || out_ready;
   assign in_ready = !s1_valid || s1_adv;

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst)           s1_valid <= 1'b0;
      else if (in_ready) s1_valid <= in_valid;
   end

`ifdef SIMD_SAT_EN
   logic s1_sat;
`else
   logic unused_sat;
   assign unused_sat = sat;
`endif

   // NOTE: stage data registers are left unreset; the valid bits alone decide what is live.
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         s1_p     <= p_next;
         s1_sub   <= op_sub;
         s1_start <= start_full[NIB-1:0];
         s1_top   <= top_full[NIB-1:0];
`ifdef SIMD_SAT_EN
         s1_sat   <= sat;
`endif
      end
   end

   // ---------------- S2: lane-bounded carry chain
   logic [W-1:0]   raw_sum, res_sum;
   logic [NIB-1:0] nib_cout, res_carry;

   for (genvar i = 0; i < NIB; i++) begin : g_nib
      logic prev, cin, c_inc, cout;
      if (i == 0) begin : g_first
         assign prev = 1'b0;
      end else begin : g_rest
         assign prev = g_nib[i-1].cout;
      end
      assign cin = s1_start[i] ? s1_sub : prev;

      // The partial sum already holds A+B; the slice only folds in the incoming carry.
      simd_nibble_add u_add (
         .a    (s1_p[i][NIB_W-1:0]),
         .b    ('0),
         .cin  (cin),
         .s    (raw_sum[NIB_W*i +: NIB_W]),
         .cout (c_inc)
      );
      assign cout        = s1_p[i][NIB_W] | c_inc;
      assign nib_cout[i] = cout;
   end

`ifdef SIMD_SAT_EN
   logic sat_hit;
`endif

   always_comb begin
      res_sum   = raw_sum;
      res_carry = nib_cout & s1_top;
`ifdef SIMD_SAT_EN
      // Walk from the top so each lane's overflow decision reaches all its lower nibbles.
      sat_hit = 1'b0;
      for (int i = NIB - 1; i >= 0; i--) begin
         if (s1_top[i]) sat_hit = s1_sat && (s1_sub ? !nib_cout[i] : nib_cout[i]);
         if (sat_hit)   res_sum[NIB_W*i +: NIB_W] = s1_sub ? '0 : '1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         carry     <= '0;
      end else if (s1_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            sum   <= res_sum;
            carry <= res_carry;
         end
      end
   end

endmodule

// File: tb/tb_simd_addsub_pipe.sv
// Self-checking bench for simd_addsub_pipe (NIB=4): directed vectors, handshake stress, reset flush.
module tb_simd_addsub_pipe;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;
`ifdef SIMD_SAT_EN
   localparam bit SAT_ON = 1'b1;
`else
   localparam bit SAT_ON = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst, in_valid, in_ready, op_sub, sat, out_valid, out_ready;
   logic [W-1:0]   dataA, dataB, sum;
   logic [1:0]     bitnum;
   logic [NIB-1:0] carry;

   simd_addsub_pipe #(.NIB(NIB)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .dataA(dataA), .dataB(dataB), .bitnum(bitnum), .op_sub(op_sub), .sat(sat),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry(carry)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0]   sum;
      logic [NIB-1:0] carry;
   } exp_t;

   exp_t           q[$];
   int             acc_q[$];
   int             n_cmp = 0, n_err = 0;
   int             cyc = 0, occ = 0;
   bit             held = 1'b0, check_lat = 1'b0, last_acc = 1'b0;
   logic [W-1:0]   held_sum;
   logic [NIB-1:0] held_carry;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: split operands into lanes and do plain integer arithmetic per lane.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] bn,
                                 input logic sub, input logic st,
                                 output logic [W-1:0] rs, output logic [NIB-1:0] rc);
      int l, lw;
      longint unsigned mask, av, bv, r, res;
      bit co;
      l = 1 << bn;
      if (l > NIB) l = NIB;
      lw   = 4 * l;
      mask = (64'd1 << lw) - 64'd1;
      rs   = '0;
      rc   = '0;
      for (int n = 0; n < NIB / l; n++) begin
         av  = (64'(a) >> (n * lw)) & mask;
         bv  = (64'(b) >> (n * lw)) & mask;
         r   = sub ? av + (~bv & mask) + 64'd1 : av + bv;
         co  = ((r >> lw) & 64'd1) != 64'd0;
         res = r & mask;
         if (SAT_ON && st) begin
            if (!sub && co) res = mask;
            if (sub && !co) res = 64'd0;
         end
         rs = rs | W'(res << (n * lw));
         rc[n * l + l - 1] = co;
      end
   endfunction

   // One clock: drive at the falling edge, sample just after, then let the rising edge act.
   task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] bn, input logic sub, input logic st, input logic ordy,
                       input logic use_x, input logic [W-1:0] xs, input logic [NIB-1:0] xc);
      exp_t           e;
      logic [W-1:0]   ms;
      logic [NIB-1:0] mc;
      int             acc;
      in_valid  = iv;
      dataA     = a;
      dataB     = b;
      bitnum    = bn;
      op_sub    = sub;
      sat       = st;
      out_ready = ordy;
      #1;
      if (held) begin
         check("hold_valid", out_valid, 1'b1);
         check("hold_sum", sum, held_sum);
         check("hold_carry", carry, held_carry);
      end
      check("in_ready", in_ready, !(occ == 2 && !ordy));
      if (out_valid && ordy) begin
         if (q.size() == 0) begin
            check("unexpected_out", out_valid, 1'b0);
         end else begin
            e   = q.pop_front();
            acc = acc_q.pop_front();
            check("sum", sum, e.sum);
            check("carry", carry, e.carry);
            if (check_lat) check("latency", cyc - acc, 2);
            occ--;
         end
      end
      held       = out_valid && !ordy;
      held_sum   = sum;
      held_carry = carry;
      last_acc   = iv && in_ready;
      if (last_acc) begin
         model(a, b, bn, sub, st, ms, mc);
         e.sum   = use_x ? xs : ms;
         e.carry = use_x ? xc : mc;
         q.push_back(e);
         acc_q.push_back(cyc);
         occ++;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, ordy, 1'b0, '0, '0);
   endtask

   task automatic dsend(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] bn,
                        input logic sub, input logic st, input logic [W-1:0] xs, input logic [NIB-1:0] xc);
      check_lat = 1'b1;
      step(1'b1, a, b, bn, sub, st, 1'b1, 1'b1, xs, xc);
      repeat (3) idle(1'b1);
      check("dir_drained", q.size(), 0);
      check_lat = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] ra, rb;
      logic [1:0]   rbn;
      logic         rsub, rsat, ordy;
      int           remaining;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dataA = '0; dataB = '0;
      bitnum = 2'b00; op_sub = 1'b0; sat = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_sum", sum, '0);
      check("rst_carry", carry, '0);
      check("rst_in_ready", in_ready, 1'b1);

      // Directed vectors with hand-derived results.
      dsend(16'h1234, 16'hFFFF, 2'b00, 1'b0, 1'b0, 16'h0123, 4'b1111);
      dsend(16'h1234, 16'hFFFF, 2'b01, 1'b0, 1'b0, 16'h1133, 4'b1010);
      dsend(16'h1234, 16'hFFFF, 2'b10, 1'b0, 1'b0, 16'h1233, 4'b1000);
      dsend(16'h1234, 16'hFFFF, 2'b11, 1'b0, 1'b0, 16'h1233, 4'b1000);
      dsend(16'h1234, 16'h0111, 2'b00, 1'b1, 1'b0, 16'h1123, 4'b1111);
      dsend(16'h0001, 16'h0002, 2'b10, 1'b1, 1'b0, 16'hFFFF, 4'b0000);
      dsend(16'h80FF, 16'h8001, 2'b01, 1'b0, 1'b1, SAT_ON ? 16'hFFFF : 16'h0000, 4'b1010);
      dsend(16'h80FF, 16'h8001, 2'b01, 1'b0, 1'b0, 16'h0000, 4'b1010);
      dsend(16'h0001, 16'h0002, 2'b10, 1'b1, 1'b1, SAT_ON ? 16'h0000 : 16'hFFFF, 4'b0000);

      // Eight back-to-back transactions with out_ready cycling 1,0,0,1.
      remaining = 8;
      ra = W'($urandom); rb = W'($urandom); rbn = 2'($urandom); rsub = 1'($urandom); rsat = 1'($urandom);
      for (int k = 0; k < 60 && (remaining > 0 || q.size() > 0); k++) begin
         ordy = (k % 4 == 0) || (k % 4 == 3);
         step(remaining > 0, ra, rb, rbn, rsub, rsat, ordy, 1'b0, '0, '0);
         if (last_acc) begin
            remaining--;
            ra = W'($urandom); rb = W'($urandom); rbn = 2'($urandom); rsub = 1'($urandom); rsat = 1'($urandom);
         end
      end
      check("stream_drained", q.size(), 0);

      // Full throughput: six inputs on consecutive cycles must all drain two cycles later.
      for (int k = 0; k < 6; k++) begin
         step(1'b1, W'($urandom), W'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0, '0, '0);
         check("tput_accept", last_acc, 1'b1);
      end
      idle(1'b1);
      idle(1'b1);
      check("tput_drained", q.size(), 0);

      // Random traffic with random backpressure.
      for (int k = 0; k < 300; k++)
         step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), 2'($urandom), 1'($urandom),
              1'($urandom), $urandom_range(0, 3) != 0, 1'b0, '0, '0);
      for (int k = 0; k < 20 && q.size() > 0; k++) idle(1'b1);
      check("rand_drained", q.size(), 0);

      // Reset with two transactions in flight.
      step(1'b1, 16'h1234, 16'h1111, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      step(1'b1, 16'h5678, 16'h1111, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_sum", sum, '0);
      check("midrst_carry", carry, '0);
      rst = 1'b0;
      q.delete();
      acc_q.delete();
      occ  = 0;
      held = 1'b0;
      for (int k = 0; k < 6; k++) begin
         check("post_rst_valid", out_valid, 1'b0);
         idle(1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
